// File: rtl/pe_pkg.sv
// Shared definitions for the PE command sequencer: PE command codes and
// the sequencer state encoding.
package pe_pkg;

  // PE command opcodes; the wider PE command field is zero-extended from these.
  typedef enum logic [4:0] {
    PE_CMD_RESET            = 5'd0,
    PE_CMD_TRIGGER          = 5'd1,
    PE_CMD_TRIGGER_LAST     = 5'd2,
    PE_CMD_SET_MUL_VAL      = 5'd3,
    PE_CMD_SET_ADD_VAL      = 5'd4,
    PE_CMD_LOAD_DATA        = 5'd5,
    PE_CMD_SET_CONV_MODE    = 5'd6,
    PE_CMD_SET_FIX_MAC_MODE = 5'd7,
    PE_CMD_FORWARD          = 5'd8,
    PE_CMD_TRIGGER_BN       = 5'd17
  } pe_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST,
    ST_CFG,
    ST_LOAD,
    ST_STREAM,
    ST_WAIT,
    ST_RESULT
  } pe_seq_state_t;

endpackage

// File: rtl/pe_cmd_seq.sv
// Command sequencer for a single PE: runs one dot-product job as
// RESET, SET_CONV_MODE, optional LOAD_DATA, N x TRIGGER, then waits for
// the PE to drain and hands its mac_value out on a valid/ready port.
module pe_cmd_seq
  import pe_pkg::*;
#(
  parameter int ACLEN      = 8,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [LEN_WIDTH-1:0]  conv_len_i,
  input  logic                  preload_en_i,
  input  logic [DATA_WIDTH-1:0] preload_data_i,
  output logic                  ready_o,
  input  logic                  op_valid_i,
  output logic                  op_ready_o,
  input  logic [DATA_WIDTH-1:0] op_data_i,
  input  logic [DATA_WIDTH-1:0] op_weight_i,
  output logic                  pe_cmd_valid_o,
  output logic [ACLEN:0]        pe_cmd_o,
  output logic [DATA_WIDTH-1:0] pe_param_1_o,
  output logic [DATA_WIDTH-1:0] pe_param_2_o,
  output logic [DATA_WIDTH-1:0] pe_preload_o,
  output logic [DATA_WIDTH-1:0] pe_data_o,
  output logic [DATA_WIDTH-1:0] pe_weight_o,
  input  logic                  pe_busy_i,
  input  logic [DATA_WIDTH-1:0] pe_mac_value_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [DATA_WIDTH-1:0] res_data_o,
  output logic                  err_o
);

  localparam int CMD_W = ACLEN + 1;
  localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  pe_seq_state_t         state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic                  pre_en_q, pre_en_d;
  logic [DATA_WIDTH-1:0] pre_data_q, pre_data_d;
  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic                  err_q, err_d;

  // Next-state, job latches, beat/timeout counters and result capture.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    state_d    = state_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    pre_en_d   = pre_en_q;
    pre_data_d = pre_data_q;
    res_data_d = res_data_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i && (conv_len_i != '0)) begin
          len_d      = conv_len_i;
          pre_en_d   = preload_en_i;
          pre_data_d = preload_data_i;
          err_d      = 1'b0;
          state_d    = ST_RST;
        end
      end
      ST_RST:  state_d = ST_CFG;
      ST_CFG:  state_d = pre_en_q ? ST_LOAD : ST_STREAM;
      ST_LOAD: state_d = ST_STREAM;
      ST_STREAM: begin
        // op_ready_o is high throughout STREAM, so a valid operand is a beat.
        if (op_valid_i) begin
          if (beat_cnt_q == len_q - LEN_WIDTH'(1)) begin
            beat_cnt_d = '0;
            tmo_cnt_d  = '0;
            state_d    = ST_WAIT;
          end else begin
            beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
          end
        end
      end
      ST_WAIT: begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        if (!pe_busy_i) begin
          res_data_d = pe_mac_value_i;
          tmo_cnt_d  = '0;
          state_d    = ST_RESULT;
        end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
          res_data_d = '0;
          err_d      = 1'b1;
          tmo_cnt_d  = '0;
          state_d    = ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (res_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset returns straight to IDLE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      beat_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      pre_en_q   <= 1'b0;
      pre_data_q <= '0;
      res_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q    <= state_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      pre_en_q   <= pre_en_d;
      pre_data_q <= pre_data_d;
      res_data_q <= res_data_d;
      err_q      <= err_d;
    end
  end

  // PE command decode from the registered state, plus operand pass-through.
  always_comb begin
    pe_cmd_valid_o = 1'b0;
    pe_cmd_o       = CMD_W'(PE_CMD_RESET);
    pe_param_1_o   = '0;
    pe_preload_o   = '0;
    pe_data_o      = '0;
    pe_weight_o    = '0;
    op_ready_o     = 1'b0;
    case (state_q)
      ST_RST: pe_cmd_valid_o = 1'b1;
      ST_CFG: begin
        pe_cmd_valid_o = 1'b1;
        pe_cmd_o       = CMD_W'(PE_CMD_SET_CONV_MODE);
        pe_param_1_o   = DATA_WIDTH'(len_q);
      end
      ST_LOAD: begin
        pe_cmd_valid_o = 1'b1;
        pe_cmd_o       = CMD_W'(PE_CMD_LOAD_DATA);
        pe_preload_o   = pre_data_q;
      end
      ST_STREAM: begin
        op_ready_o     = 1'b1;
        pe_cmd_valid_o = op_valid_i;
        pe_cmd_o       = CMD_W'(PE_CMD_TRIGGER);
        pe_data_o      = op_data_i;
        pe_weight_o    = op_weight_i;
      end
      default: ;
    endcase
  end

  assign pe_param_2_o = '0;
  assign ready_o      = (state_q == ST_IDLE);
  assign res_valid_o  = (state_q == ST_RESULT);
  assign res_data_o   = res_data_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_pe_cmd_seq.sv
// Self-checking bench for pe_cmd_seq: a behavioural PE model drives busy and
// mac_value; each job's command trace, operand pass-through, result latency,
// result value and error flag are compared against expectations built here.
`timescale 1ns/1ps
module tb_pe_cmd_seq;
  import pe_pkg::*;

  localparam int ACLEN = 8;
  localparam int DW    = 32;
  localparam int LW    = 16;
  localparam int TMO   = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i, preload_en_i, op_valid_i, res_ready_i;
  logic [LW-1:0] conv_len_i;
  logic [DW-1:0] preload_data_i, op_data_i, op_weight_i;
  logic          ready_o, op_ready_o, pe_cmd_valid_o, res_valid_o, err_o;
  logic [ACLEN:0] pe_cmd_o;
  logic [DW-1:0] pe_param_1_o, pe_param_2_o, pe_preload_o, pe_data_o, pe_weight_o;
  logic [DW-1:0] res_data_o, pe_mac_value_i;
  logic          pe_busy_i;

  always #5 clk_i = ~clk_i;

  pe_cmd_seq #(.ACLEN(ACLEN), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .conv_len_i(conv_len_i),
    .preload_en_i(preload_en_i), .preload_data_i(preload_data_i), .ready_o(ready_o),
    .op_valid_i(op_valid_i), .op_ready_o(op_ready_o), .op_data_i(op_data_i),
    .op_weight_i(op_weight_i), .pe_cmd_valid_o(pe_cmd_valid_o), .pe_cmd_o(pe_cmd_o),
    .pe_param_1_o(pe_param_1_o), .pe_param_2_o(pe_param_2_o), .pe_preload_o(pe_preload_o),
    .pe_data_o(pe_data_o), .pe_weight_o(pe_weight_o), .pe_busy_i(pe_busy_i),
    .pe_mac_value_i(pe_mac_value_i), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_data_o(res_data_o), .err_o(err_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- command monitor ----------------
  typedef struct {
    logic [ACLEN:0] cmd;
    logic [DW-1:0]  p1, p2, pre, d, w;
    int             cyc;
  } cmd_rec_t;

  cmd_rec_t    obs_q[$];
  logic [63:0] exp_ops[$];
  int          cyc = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i)
    if (!rst_i && pe_cmd_valid_o)
      obs_q.push_back('{cmd: pe_cmd_o, p1: pe_param_1_o, p2: pe_param_2_o,
                        pre: pe_preload_o, d: pe_data_o, w: pe_weight_o, cyc: cyc});

  // ---------------- behavioural PE ----------------
  logic          stuck = 1'b0;
  int            drain_cfg = 1;
  int            job_len = 0;
  int            trig = 0;
  int            dcnt = 0;
  logic [DW-1:0] mac_cfg = '0;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pe_busy_i <= 1'b0; trig <= 0; dcnt <= 0;
    end else if (pe_cmd_valid_o && pe_cmd_o == 9'd0) begin
      pe_busy_i <= 1'b0; trig <= 0;
    end else if (pe_cmd_valid_o && pe_cmd_o == 9'd1) begin
      pe_busy_i <= 1'b1;
      trig <= trig + 1;
      if (trig + 1 == job_len) dcnt <= drain_cfg;
    end else if (pe_busy_i && trig == job_len && !stuck) begin
      if (dcnt <= 1) pe_busy_i <= 1'b0;
      dcnt <= dcnt - 1;
    end
  end

  assign pe_mac_value_i = pe_busy_i ? 32'hDEAD_BEEF : mac_cfg;

  // ---------------- job tasks ----------------
  task automatic start_job(input int len, input logic pe, input logic [DW-1:0] pv);
    int g;
    g = 0;
    while (!ready_o && g < 50) begin @(posedge clk_i); #1; g++; end
    job_len = len;
    obs_q.delete();
    exp_ops.delete();
    start_i = 1'b1; conv_len_i = LW'(len); preload_en_i = pe; preload_data_i = pv;
    @(negedge clk_i);
    check("start_ready", ready_o, 1);
    @(posedge clk_i); #1;
    start_i = 1'b0; conv_len_i = LW'($urandom); preload_en_i = 1'($urandom);
    preload_data_i = $urandom;
    @(negedge clk_i);
    check("err_clr", err_o, 0);
    check("ready_busy", ready_o, 0);
    @(posedge clk_i); #1;
  endtask

  // mode 0: back-to-back, 1: fixed stall pattern, 2: random stalls + noise on start
  task automatic stream_ops(input int mode, input int stop_after);
    int   acc, pidx, guard;
    logic v;
    logic pat[7];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    acc = 0; pidx = 0; guard = 0;
    while (acc < stop_after && guard < 400) begin
      guard++;
      case (mode)
        0:       v = 1'b1;
        1:       v = (pidx < 7) ? pat[pidx] : 1'b1;
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      op_valid_i = v; op_data_i = $urandom; op_weight_i = $urandom;
      if (mode == 2) begin start_i = 1'($urandom); conv_len_i = LW'($urandom); end
      @(negedge clk_i);
      if (op_ready_o) begin
        pidx++;
        if (op_valid_i) begin
          acc++;
          exp_ops.push_back({op_data_i, op_weight_i});
        end
      end
      @(posedge clk_i); #1;
    end
    op_valid_i = 1'b0; start_i = 1'b0;
    check("stream_beats", acc, stop_after);
  endtask

  task automatic finish_job(input int len, input logic pe, input logic [DW-1:0] pv,
                            input int ready_delay);
    int            g, base, lat, exp_lat;
    logic [DW-1:0] exp_res, p2_or;
    exp_res = stuck ? '0 : mac_cfg;
    exp_lat = stuck ? TMO + 1 : drain_cfg + 2;
    g = 0;
    do begin @(negedge clk_i); g++; end while (!res_valid_o && g < 200);
    check("res_seen", res_valid_o, 1);
    check("ready_in_result", ready_o, 0);
    lat = (obs_q.size() > 0) ? cyc - obs_q[obs_q.size()-1].cyc : -1;
    check("wait_latency", lat, exp_lat);
    check("res_data", res_data_o, exp_res);
    check("err_flag", err_o, stuck);
    // command trace: RESET, SET_CONV_MODE, [LOAD_DATA], TRIGGER x len
    check("n_cmds", obs_q.size(), 2 + int'(pe) + len);
    check("n_ops", exp_ops.size(), len);
    if (obs_q.size() == 2 + int'(pe) + len && exp_ops.size() == len) begin
      check("cmd_reset", obs_q[0].cmd, 0);
      check("cmd_cfg", obs_q[1].cmd, 6);
      check("cfg_len", obs_q[1].p1, len);
      if (pe) begin
        check("cmd_load", obs_q[2].cmd, 5);
        check("load_val", obs_q[2].pre, pv);
      end
      base = 2 + int'(pe);
      for (int i = 0; i < len; i++) begin
        check("cmd_trig", obs_q[base+i].cmd, 1);
        check("trig_ops", {obs_q[base+i].d, obs_q[base+i].w}, exp_ops[i]);
      end
    end
    p2_or = '0;
    foreach (obs_q[i]) p2_or |= obs_q[i].p2;
    check("param2_zero", p2_or, 0);
    // backpressure: result must hold until accepted
    for (int k = 0; k < ready_delay; k++) begin
      @(negedge clk_i);
      check("res_hold_valid", res_valid_o, 1);
      check("res_hold_data", res_data_o, exp_res);
    end
    res_ready_i = 1'b1;
    @(negedge clk_i);
    res_ready_i = 1'b0;
    check("res_done", res_valid_o, 0);
    check("idle_again", ready_o, 1);
    @(posedge clk_i); #1;
  endtask

  task automatic run_job(input int len, input logic pe, input logic [DW-1:0] pv,
                         input logic [DW-1:0] mac, input int drain, input logic stk,
                         input int mode, input int ready_delay);
    mac_cfg = mac; drain_cfg = drain; stuck = stk;
    start_job(len, pe, pv);
    stream_ops(mode, len);
    finish_job(len, pe, pv, ready_delay);
    stuck = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_i = 1'b1; start_i = 1'b0; conv_len_i = '0; preload_en_i = 1'b0;
    preload_data_i = '0; op_valid_i = 1'b0; op_data_i = '0; op_weight_i = '0;
    res_ready_i = 1'b0;
    #12;
    check("rst_ready", ready_o, 1);
    check("rst_cmd_valid", pe_cmd_valid_o, 0);
    check("rst_op_ready", op_ready_o, 0);
    check("rst_res_valid", res_valid_o, 0);
    check("rst_res_data", res_data_o, 0);
    check("rst_err", err_o, 0);
    #10 rst_i = 1'b0;
    @(posedge clk_i); #1;

    // basic job
    run_job(4, 1'b0, '0, 32'h4120_0000, 10, 1'b0, 0, 0);
    // preload
    run_job(3, 1'b1, 32'h3F80_0000, 32'h4000_0000, 4, 1'b0, 0, 1);
    // stalls and backpressure
    run_job(4, 1'b0, '0, 32'h4040_0000, 6, 1'b0, 1, 5);

    // zero length start is ignored
    obs_q.delete();
    start_i = 1'b1; conv_len_i = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      check("len0_ready", ready_o, 1);
      @(posedge clk_i); #1;
    end
    start_i = 1'b0;
    @(negedge clk_i);
    check("len0_no_cmds", obs_q.size(), 0);
    @(posedge clk_i); #1;

    // single beat
    run_job(1, 1'b0, '0, 32'hC2C8_0000, 3, 1'b0, 0, 0);
    // timeout, then a clean job clears err
    run_job(2, 1'b0, '0, 32'h1234_5678, 3, 1'b1, 0, 1);
    run_job(2, 1'b1, 32'h4080_0000, 32'h3F00_0000, 2, 1'b0, 0, 0);

    // async reset mid-stream at beat 2 of 8
    mac_cfg = 32'h0BAD_F00D; drain_cfg = 5;
    start_job(8, 1'b0, '0);
    stream_ops(0, 2);
    op_valid_i = 1'b1;
    #2;
    check("pre_rst_op_ready", op_ready_o, 1);
    rst_i = 1'b1;
    #1;
    check("midrst_cmd_valid", pe_cmd_valid_o, 0);
    check("midrst_op_ready", op_ready_o, 0);
    check("midrst_ready", ready_o, 1);
    op_valid_i = 1'b0;
    @(posedge clk_i); #3;
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    run_job(8, 1'b0, '0, 32'h4110_0000, 7, 1'b0, 0, 0);

    // randomized jobs
    for (int j = 0; j < 12; j++)
      run_job($urandom_range(1, 6), 1'($urandom), $urandom, $urandom,
              $urandom_range(1, 12), 1'b0, 2, $urandom_range(0, 3));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pe_cmd_seq.md
# pe_cmd_seq

Command sequencer that sits directly upstream of a single PE. It accepts one dot-product job: length, optional preload value and a stream of (data, weight) operand pairs. It issues the PE command sequence RESET → SET_CONV_MODE → [LOAD_DATA] → TRIGGER×N, waits for the PE to drain, and returns the PE's accumulated `mac_value` on a valid/ready result port.

## Interface
- `ACLEN`, 8, PE command field is `ACLEN+1` bits
- `DATA_WIDTH`, 32, operand/result width (FP32 bit patterns, never interpreted)
- `LEN_WIDTH`, 16, job length counter width
- `TIMEOUT`, 1024, max cycles in WAIT before error
- `clk_i`  in  1  single clock
- `rst_i`  in  1  asynchronous, active-high reset
- `start_i`  in  1  job request, sampled only in IDLE
- `conv_len_i`  in  LEN_WIDTH  number of operand beats N
- `preload_en_i`  in  1  issue LOAD_DATA before streaming
- `preload_data_i`  in  DATA_WIDTH  preload value
- `ready_o`  out  1  high in IDLE
- `op_valid_i` / `op_ready_o`  in/out  1  operand handshake
- `op_data_i`, `op_weight_i`  in  DATA_WIDTH  operand pair
- `pe_cmd_valid_o`  out  1;  `pe_cmd_o`  out  ACLEN+1
- `pe_param_1_o`, `pe_param_2_o`, `pe_preload_o`, `pe_data_o`, `pe_weight_o`  out  DATA_WIDTH
- `pe_busy_i`  in  1;  `pe_mac_value_i`  in  DATA_WIDTH
- `res_valid_o`  out  1;  `res_ready_i`  in  1;  `res_data_o`  out  DATA_WIDTH
- `err_o`  out  1  sticky timeout flag, cleared by next accepted start

## Operation
- FSM states: IDLE, RST, CFG, LOAD, STREAM, WAIT, RESULT.
- IDLE: `start_i=1` with `conv_len_i!=0` latches len/preload → RST, clears `err_o`. `start_i` with `conv_len_i==0` is ignored.
- RST: one cycle, `pe_cmd_o=RESET(0)` → CFG.
- CFG: one cycle, `SET_CONV_MODE(6)`, `pe_param_1_o=len` zero-extended → LOAD if preload latched, otherwise STREAM.
- LOAD: one cycle, `LOAD_DATA(5)`, `pe_preload_o=preload` → STREAM.
- STREAM: `op_ready_o=1`; `pe_cmd_valid_o=op_valid_i`, `pe_cmd_o=TRIGGER(1)`, `pe_data_o/pe_weight_o=op_*_i` combinational pass-through. Each beat with `op_valid_i&&op_ready_o` increments `beat_cnt`. The beat with `beat_cnt==len-1` → WAIT, and `beat_cnt` clears.
- WAIT: no command issued. Timeout counter increments each cycle. First cycle with `pe_busy_i==0` captures `pe_mac_value_i` into `res_data_o` → RESULT. Counter reaching TIMEOUT-1 sets `err_o`, forces `res_data_o=0` → RESULT.
- RESULT: `res_valid_o=1`, data stable; `res_ready_i=1` → IDLE.
- Outside the states named above, `pe_cmd_valid_o=0` and `op_ready_o=0`. `pe_param_2_o` is always 0.

## Timing
- Reset values (async): state IDLE, `ready_o=1`, and every other output, counter and register 0.
- State, counters, `res_data_o` and `err_o` are registered. PE command outputs are combinational decode of state, plus operand pass-through in STREAM.
- Minimum job latency from start accept to `res_valid_o`: 3 (+1 preload) + N + PE drain cycles + 1.
- `pe_busy_i` rises on the edge that accepts the first TRIGGER, so it is already 1 on WAIT entry. No settle cycle is needed. `pe_mac_value_i` is valid in the same cycle `pe_busy_i` falls.
- Operand stall (`op_valid_i=0`) in STREAM inserts bubbles with no PE command. The count is unaffected.
- `start_i` outside IDLE is ignored. `res_ready_i` outside RESULT is ignored.
- `res_ready_i` held high: RESULT lasts exactly one cycle. `start_i` in that same cycle is not accepted; it is accepted in the following IDLE cycle.
- `len=1`: a single STREAM beat goes straight to WAIT.
- `beat_cnt` never wraps, because `len ≤ 2^LEN_WIDTH-1`.
- Reset mid-job: the FSM returns to IDLE immediately and no further PE commands are issued. The PE is restored by its own reset or by the next job's RESET.

## Structure
- Shared package `pe_pkg`:
  - PE command codes: RESET=0, TRIGGER=1, TRIGGER_LAST=2, SET_MUL_VAL=3, SET_ADD_VAL=4, LOAD_DATA=5, SET_CONV_MODE=6, SET_FIX_MAC_MODE=7, FORWARD=8, TRIGGER_BN=17.
  - `pe_seq_state_t` enum.
- No sub-module. FSM, beat counter and timeout counter live in one module.

## Test plan
- Basic job: len=4, no preload, operands streamed back-to-back, PE model drops busy 10 cycles after last TRIGGER with mac=0x41200000 → command trace 0,6,1,1,1,1; `pe_param_1_o=4` in CFG; `res_data_o=0x41200000`.
- Preload: `preload_en=1`, data 0x3F800000 → LOAD_DATA issued between CFG and first TRIGGER, with `pe_preload_o=0x3F800000`.
- Stalls and backpressure: `op_valid_i` toggling 1,0,0,1,1,0,1 for len=4, then `res_ready_i` low for 5 cycles → exactly 4 TRIGGERs, and result held stable until accepted.
- Edge lengths: `conv_len=0` start → `ready_o` stays 1 and no commands are issued. `len=1` → a single TRIGGER, then WAIT.
- Timeout: TIMEOUT=16 and `pe_busy_i` stuck at 1 → `err_o=1` and `res_data_o=0` after 16 WAIT cycles. The next start clears `err_o`.
- Async reset asserted mid-STREAM (beat 2 of 8) → `pe_cmd_valid_o` and `op_ready_o` are 0 immediately and `ready_o=1`. A fresh job then completes correctly.
